retire_trace_buffer: RTL and testbench

Synthesizable retirement-trace capture block for the pipelined 16-bit processor. It samples the writeback-stage commit signals each cycle, classifies each retired instruction, and stamps it with an instruction number. The resulting record goes into a parametrised FIFO, drained by a valid/ready consumer such as a debug port or a bench trace writer. It replaces ad-hoc testbench-side trace logic with a design-side, depth-bounded, overflow-aware monitor that also keeps cycle and instruction counters and a halt/drain handshake.

---
 rtl/retire_trace_buffer_if.sv | 48 ++++
 rtl/retire_trace_buffer.sv | 155 +++++++++++++++
 tb/tb_retire_trace_buffer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/retire_trace_buffer_if.sv
// Commit/record bus for the retirement trace buffer.
//   commit_* side : writeback-stage retire signals driven by the core
//                   (commit_valid, pc, reg_wrt, wr_reg, wr_data, mem_read,
//                   mem_write, mem_addr, mem_data, halt)
//   rec_* side    : valid/ready record stream toward the trace consumer
//                   (rec_valid, rec_ready, rec_kind, rec_inum, rec_pc,
//                   rec_value, rec_addr, rec_mdata, rec_reg)
// master = the trace buffer, slave = core + consumer (or a bench).
interface retire_trace_buffer_if #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3,
    parameter int CNT_W  = 32
);
    logic              commit_valid;
    logic [DATA_W-1:0] pc;
    logic              reg_wrt;
    logic [REG_AW-1:0] wr_reg;
    logic [DATA_W-1:0] wr_data;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              halt;

    logic              rec_valid;
    logic              rec_ready;
    logic [2:0]        rec_kind;
    logic [CNT_W-1:0]  rec_inum;
    logic [DATA_W-1:0] rec_pc;
    logic [DATA_W-1:0] rec_value;
    logic [DATA_W-1:0] rec_addr;
    logic [DATA_W-1:0] rec_mdata;
    logic [REG_AW-1:0] rec_reg;

    modport master (
        input  commit_valid, pc, reg_wrt, wr_reg, wr_data,
               mem_read, mem_write, mem_addr, mem_data, halt, rec_ready,
        output rec_valid, rec_kind, rec_inum, rec_pc, rec_value,
               rec_addr, rec_mdata, rec_reg
    );

    modport slave (
        output commit_valid, pc, reg_wrt, wr_reg, wr_data,
               mem_read, mem_write, mem_addr, mem_data, halt, rec_ready,
        input  rec_valid, rec_kind, rec_inum, rec_pc, rec_value,
               rec_addr, rec_mdata, rec_reg
    );
endinterface

// File: rtl/retire_trace_buffer.sv
// Retirement-trace capture: classifies each retiring instruction, stamps it
// with an instruction number and queues it in a DEPTH-entry FIFO drained by
// a valid/ready consumer.
// Ports:
//   clk         - single clock, rising edge
//   rst         - synchronous active-low reset
//   bus         - commit inputs and rec_* record stream (master modport)
//   cycle_count - cycles since reset release
//   inst_count  - commits observed while not halted, including dropped ones
//   overflow    - sticky, at least one record was dropped
//   halted      - a HALT commit has been observed
//   done        - the HALT record has been consumed
module retire_trace_buffer #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    retire_trace_buffer_if.master bus,
    output logic [CNT_W-1:0]      cycle_count,
    output logic [CNT_W-1:0]      inst_count,
    output logic                  overflow,
    output logic                  halted,
    output logic                  done
);
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = AW + 1;

    typedef enum logic [2:0] {
        K_NOP  = 3'd0,
        K_REG  = 3'd1,
        K_LD   = 3'd2,
        K_ST   = 3'd3,
        K_STU  = 3'd4,
        K_HALT = 3'd5
    } kind_e;

    typedef enum logic [1:0] {
        S_TRACE,
        S_HALTED,
        S_DONE
    } state_e;

    state_e state, stateNext;

    kind_e             kindMem  [DEPTH];
    logic [CNT_W-1:0]  inumMem  [DEPTH];
    logic [DATA_W-1:0] pcMem    [DEPTH];
    logic [DATA_W-1:0] valueMem [DEPTH];
    logic [DATA_W-1:0] addrMem  [DEPTH];
    logic [DATA_W-1:0] mdataMem [DEPTH];
    logic [REG_AW-1:0] regMem   [DEPTH];

    logic [AW-1:0]    wrPtr, rdPtr;
    logic [OCC_W-1:0] occ;

    logic  full, empty, popEn, capture, pushEn, dropEn;
    kind_e kindNow;

    // Priority classification; HALT overrides every other flag.
    always_comb begin
        kindNow = K_NOP;
        if (bus.halt)                         kindNow = K_HALT;
        else if (bus.reg_wrt && bus.mem_write) kindNow = K_STU;
        else if (bus.reg_wrt && bus.mem_read)  kindNow = K_LD;
        else if (bus.reg_wrt)                  kindNow = K_REG;
        else if (bus.mem_write)                kindNow = K_ST;
    end

    always_comb begin
        full    = (occ == OCC_W'(DEPTH));
        empty   = (occ == '0);
        popEn   = !empty && bus.rec_ready;
        capture = bus.commit_valid && (state == S_TRACE);
        // A pop in the same cycle frees the slot a full FIFO needs.
        pushEn  = capture && (!full || popEn);
        dropEn  = capture && !pushEn;
    end

    // Record storage needs no reset: outputs are masked while empty.
    always_ff @(posedge clk) begin
        if (pushEn) begin
            kindMem[wrPtr]  <= kindNow;
            inumMem[wrPtr]  <= inst_count;
            pcMem[wrPtr]    <= bus.pc;
            valueMem[wrPtr] <= bus.wr_data;
            addrMem[wrPtr]  <= bus.mem_addr;
            mdataMem[wrPtr] <= bus.mem_data;
            regMem[wrPtr]   <= bus.wr_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wrPtr       <= '0;
            rdPtr       <= '0;
            occ         <= '0;
            cycle_count <= '0;
            inst_count  <= '0;
            overflow    <= 1'b0;
        end else begin
            cycle_count <= cycle_count + CNT_W'(1);
            if (capture) inst_count <= inst_count + CNT_W'(1);
            if (dropEn)  overflow   <= 1'b1;
            if (pushEn)  wrPtr      <= wrPtr + AW'(1);
            if (popEn)   rdPtr      <= rdPtr + AW'(1);
            if (pushEn && !popEn)      occ <= occ + OCC_W'(1);
            else if (popEn && !pushEn) occ <= occ - OCC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= S_TRACE;
        else      state <= stateNext;
    end

    // A HALT commit halts capture even when its record is dropped; done only
    // follows when the HALT record itself leaves the FIFO.
    always_comb begin
        stateNext = state;
        case (state)
            S_TRACE:  if (capture && kindNow == K_HALT) stateNext = S_HALTED;
            S_HALTED: if (popEn && kindMem[rdPtr] == K_HALT) stateNext = S_DONE;
            S_DONE:   stateNext = S_DONE;
            default:  stateNext = S_TRACE;
        endcase
    end

    always_comb begin
        halted = (state != S_TRACE);
        done   = (state == S_DONE);
    end

    always_comb begin
        bus.rec_valid = !empty;
        bus.rec_kind  = '0;
        bus.rec_inum  = '0;
        bus.rec_pc    = '0;
        bus.rec_value = '0;
        bus.rec_addr  = '0;
        bus.rec_mdata = '0;
        bus.rec_reg   = '0;
        if (!empty) begin
            bus.rec_kind  = kindMem[rdPtr];
            bus.rec_inum  = inumMem[rdPtr];
            bus.rec_pc    = pcMem[rdPtr];
            bus.rec_value = valueMem[rdPtr];
            bus.rec_addr  = addrMem[rdPtr];
            bus.rec_mdata = mdataMem[rdPtr];
            bus.rec_reg   = regMem[rdPtr];
        end
    end
endmodule

// File: tb/tb_retire_trace_buffer.sv
module tb_retire_trace_buffer;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] cycleCount, instCount;
    logic        overflow, halted, done;

    retire_trace_buffer_if #(.DATA_W(16), .REG_AW(3), .CNT_W(32)) bus ();

    retire_trace_buffer #(.DATA_W(16), .REG_AW(3), .DEPTH(DEPTH), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .cycle_count(cycleCount), .inst_count(instCount),
        .overflow(overflow), .halted(halted), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  kind;
        logic [31:0] inum;
        logic [15:0] pc, value, addr, mdata;
        logic [2:0]  rg;
    } rec_t;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: a record queue plus counters, updated once per edge.
    rec_t        q[$];
    rec_t        popLog[$];
    rec_t        r;
    logic [31:0] mCyc = 0, mInst = 0;
    bit          mOvf = 0, mHalt = 0, mDone = 0, popNow;

    function automatic logic [2:0] classify();
        if (bus.halt)                          return 3'd5;
        if (bus.reg_wrt && bus.mem_write)      return 3'd4;
        if (bus.reg_wrt && bus.mem_read)       return 3'd2;
        if (bus.reg_wrt)                       return 3'd1;
        if (bus.mem_write)                     return 3'd3;
        return 3'd0;
    endfunction

    // Inputs change only at negedge+1, so here they still hold what the
    // preceding rising edge sampled.
    always @(negedge clk) begin
        if (!rst) begin
            q.delete();
            mCyc = 0; mInst = 0; mOvf = 0; mHalt = 0; mDone = 0;
        end else begin
            mCyc++;
            popNow = (q.size() > 0) && bus.rec_ready;
            if (popNow) begin
                if (q[0].kind == 3'd5) mDone = 1;
                popLog.push_back(q[0]);
                void'(q.pop_front());
            end
            if (bus.commit_valid && !mHalt) begin
                r.kind = classify(); r.inum = mInst; r.pc = bus.pc;
                r.value = bus.wr_data; r.addr = bus.mem_addr;
                r.mdata = bus.mem_data; r.rg = bus.wr_reg;
                mInst++;
                if (q.size() < DEPTH) q.push_back(r);
                else mOvf = 1;
                if (r.kind == 3'd5) mHalt = 1;
            end
        end
        check("rec_valid", bus.rec_valid, q.size() > 0);
        if (q.size() > 0) begin
            check("rec_kind",  bus.rec_kind,  q[0].kind);
            check("rec_inum",  bus.rec_inum,  q[0].inum);
            check("rec_pc",    bus.rec_pc,    q[0].pc);
            check("rec_value", bus.rec_value, q[0].value);
            check("rec_addr",  bus.rec_addr,  q[0].addr);
            check("rec_mdata", bus.rec_mdata, q[0].mdata);
            check("rec_reg",   bus.rec_reg,   q[0].rg);
        end else begin
            check("rec_empty_zero", {bus.rec_kind, bus.rec_inum, bus.rec_pc, bus.rec_reg}, '0);
            check("rec_empty_zero2", {bus.rec_value, bus.rec_addr, bus.rec_mdata}, '0);
        end
        check("cycle_count", cycleCount, mCyc);
        check("inst_count",  instCount,  mInst);
        check("overflow",    overflow,   mOvf);
        check("halted",      halted,     mHalt);
        check("done",        done,       mDone);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        bus.commit_valid = 0; bus.reg_wrt = 0; bus.mem_read = 0;
        bus.mem_write = 0; bus.halt = 0;
    endtask

    task automatic commit(input logic [15:0] p, input logic rw, input logic [2:0] rg,
                          input logic [15:0] wd, input logic mr, input logic mw,
                          input logic [15:0] ma, input logic [15:0] md, input logic h);
        bus.commit_valid = 1; bus.pc = p; bus.reg_wrt = rw; bus.wr_reg = rg;
        bus.wr_data = wd; bus.mem_read = mr; bus.mem_write = mw;
        bus.mem_addr = ma; bus.mem_data = md; bus.halt = h;
        step();
        idle();
    endtask

    task automatic resetDut();
        rst = 0;
        step();
        rst = 1;
        popLog.delete();
    endtask

    initial begin
        idle();
        bus.pc = 0; bus.wr_reg = 0; bus.wr_data = 0; bus.mem_addr = 0;
        bus.mem_data = 0; bus.rec_ready = 0;
        step(); step();
        check("reset_valid", bus.rec_valid, 0);
        check("reset_cycle", cycleCount, 0);
        check("reset_halted", halted, 0);
        rst = 1;

        // Mixed retire with a ready consumer.
        bus.rec_ready = 1;
        commit(16'h0002, 1, 3'd3, 16'h1234, 0, 0, 16'h0000, 16'h0000, 0);
        check("mix_lat_valid", bus.rec_valid, 1);
        check("mix_lat_kind", bus.rec_kind, 1);
        check("mix_lat_value", bus.rec_value, 16'h1234);
        commit(16'h0004, 0, 3'd0, 16'h0000, 0, 1, 16'h0040, 16'hBEEF, 0);
        check("mix_st_kind", bus.rec_kind, 3);
        check("mix_st_mdata", bus.rec_mdata, 16'hBEEF);
        commit(16'h0006, 1, 3'd1, 16'h5555, 1, 0, 16'h0040, 16'h0000, 0);
        commit(16'h0008, 0, 3'd0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0);
        step(); step();
        check("mix_pops", popLog.size(), 4);
        if (popLog.size() == 4) begin
            check("mix_k0", popLog[0].kind, 1); check("mix_k1", popLog[1].kind, 3);
            check("mix_k2", popLog[2].kind, 2); check("mix_k3", popLog[3].kind, 0);
            for (int i = 0; i < 4; i++) check("mix_inum", popLog[i].inum, i);
        end
        check("mix_overflow", overflow, 0);

        // Overflow, then a push+pop on a full FIFO.
        resetDut();
        bus.rec_ready = 0;
        for (int i = 0; i < 10; i++) begin
            logic [2:0] f;
            f = 3'(i);
            commit(16'h0100 + 16'(i), f[0], 3'(i), 16'(i * 3), f[2], f[1], 16'(i), 16'(~i), 0);
        end
        check("ovf_inst", instCount, 10);
        check("ovf_flag", overflow, 1);
        bus.rec_ready = 1;
        commit(16'h0200, 1, 3'd7, 16'h7777, 0, 0, 16'h0000, 16'h0000, 0);
        check("full_pushpop_inst", instCount, 11);
        for (int i = 0; i < 10; i++) step();
        check("ovf_pops", popLog.size(), 9);
        if (popLog.size() == 9) begin
            for (int i = 0; i < 8; i++) check("ovf_inum", popLog[i].inum, i);
            check("full_8th_inum", popLog[8].inum, 10);
            check("full_8th_pc", popLog[8].pc, 16'h0200);
            check("ovf_k1_reg", popLog[1].kind, 1);
            check("ovf_k3_stu", popLog[3].kind, 4);
            check("ovf_k5_ld", popLog[5].kind, 2);
        end

        // Halt handshake.
        resetDut();
        bus.rec_ready = 0;
        commit(16'h0010, 1, 3'd2, 16'h0001, 0, 0, 16'h0000, 16'h0000, 0);
        check("halt_pre", halted, 0);
        commit(16'h0012, 1, 3'd4, 16'h0002, 0, 1, 16'h0000, 16'h0000, 1);
        check("halt_rise", halted, 1);
        commit(16'h0014, 1, 3'd5, 16'h0003, 0, 0, 16'h0000, 16'h0000, 0);
        step();
        check("halt_inst", instCount, 2);
        bus.rec_ready = 1;
        step();
        check("halt_done_early", done, 0);
        step();
        check("halt_done", done, 1);
        check("halt_pops", popLog.size(), 2);
        if (popLog.size() == 2) begin
            check("halt_kind", popLog[1].kind, 5);
            check("halt_inum", popLog[1].inum, 1);
        end
        step();

        // Dropped HALT: halted but never done.
        resetDut();
        bus.rec_ready = 0;
        for (int i = 0; i < 8; i++)
            commit(16'h0400 + 16'(i), 1, 3'd1, 16'(i), 0, 0, 16'h0000, 16'h0000, 0);
        commit(16'h0420, 0, 3'd0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1);
        check("drophalt_halted", halted, 1);
        check("drophalt_ovf", overflow, 1);
        bus.rec_ready = 1;
        for (int i = 0; i < 12; i++) step();
        check("drophalt_done", done, 0);

        // Back-pressure.
        resetDut();
        bus.rec_ready = 0;
        commit(16'h0300, 1, 3'd6, 16'hA5A5, 0, 0, 16'h0000, 16'h0000, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_value", bus.rec_value, 16'hA5A5);
        end
        bus.rec_ready = 1;
        step();
        check("bp_popped", bus.rec_valid, 0);
        check("bp_pops", popLog.size(), 1);

        // Mid-run reset with records queued.
        bus.rec_ready = 0;
        for (int i = 0; i < 3; i++)
            commit(16'h0500 + 16'(i), 1, 3'd2, 16'(i), 0, 0, 16'h0000, 16'h0000, 0);
        commit(16'h0510, 0, 3'd0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1);
        check("mid_halted_before", halted, 1);
        rst = 0;
        step();
        check("mid_valid", bus.rec_valid, 0);
        check("mid_cycle", cycleCount, 0);
        check("mid_inst", instCount, 0);
        check("mid_ovf", overflow, 0);
        check("mid_halted", halted, 0);
        rst = 1;
        step(); step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
